// File: rtl/camera_move_ctrl.sv
// Camera-update sequencer: phase ring, button sync/arbitration, hold timing, frame-gated update issue.
// Optional feature macro: CAM_AUTOREPEAT_EN (periodic updates while a button stays held).
module camera_move_ctrl #(
  parameter int UPDATE_PERIOD = 5_000_000,
  parameter int SETTLE_CYC    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  btn,
  input  logic        frame_done,
  output logic        v0,
  output logic        v1,
  output logic        v2,
  output logic        ld_curr_camera,
  output logic [2:0]  key,
  output logic [31:0] cnt,
  output logic        busy
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC);
  localparam logic [31:0]   PERIOD      = 32'(UPDATE_PERIOD);
`ifdef CAM_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, PEND, SETTLE} state_t;

  state_t         state, state_d;
  logic [2:0]     phase;
  logic [5:0]     s1, sb;
  logic [2:0]     gkey, gkey_d, prio;
  logic [31:0]    hc, hc_d;
  logic [SW-1:0]  sc, sc_d;
  logic [2:0]     key_r;
  logic [31:0]    cnt_r;
  logic           held;

  assign v0   = phase[0];
  assign v1   = phase[1];
  assign v2   = phase[2];
  assign busy = (state != IDLE);
  assign held = |(sb & (6'b000001 << gkey));

  // key/cnt show the new values in the issue cycle itself and hold them afterwards
  assign key = ld_curr_camera ? gkey : key_r;
  assign cnt = ld_curr_camera ? hc   : cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 3'b001;
      s1    <= '0;
      sb    <= '0;
      state <= IDLE;
      gkey  <= '0;
      hc    <= '0;
      sc    <= '0;
      key_r <= '0;
      cnt_r <= '0;
    end else begin
      phase <= {phase[1:0], phase[2]};
      s1    <= btn;
      sb    <= s1;
      state <= state_d;
      gkey  <= gkey_d;
      hc    <= hc_d;
      sc    <= sc_d;
      if (ld_curr_camera) begin
        key_r <= gkey;
        cnt_r <= hc;
      end
    end
  end

  // Lowest set index wins: scanning downward lets the smallest index overwrite last
  always_comb begin
    prio = '0;
    for (int i = 5; i >= 0; i--) begin
      if (sb[i]) prio = 3'(i);
    end
  end

  always_comb begin
    state_d        = state;
    gkey_d         = gkey;
    hc_d           = hc;
    sc_d           = sc;
    ld_curr_camera = 1'b0;
    case (state)
      IDLE: begin
        hc_d = '0;
        if (|sb) begin
          gkey_d  = prio;
          hc_d    = 32'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held || (AUTO && (hc == PERIOD))) begin
          state_d = PEND;
        end else if (hc != '1) begin
          hc_d = hc + 32'd1;
        end
      end
      PEND: begin
        // Issue on v0 so the x/y/z sweep begins on the following v2
        if (frame_done && phase[0]) begin
          ld_curr_camera = 1'b1;
          sc_d           = SETTLE_LOAD;
          state_d        = SETTLE;
        end
      end
      SETTLE: begin
        if (sc == '0) begin
          if (AUTO && held) begin
            hc_d    = 32'd1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sc_d = sc - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_camera_move_ctrl.sv
// Scoreboard bench for camera_move_ctrl: stimulus pushes expected key/cnt, a monitor checks each update pulse.
module tb_camera_move_ctrl;

  localparam int UP = 16;
  localparam int SC = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  btn;
  logic        frame_done;
  logic        v0, v1, v2;
  logic        ld_curr_camera;
  logic [2:0]  key;
  logic [31:0] cnt;
  logic        busy;

  typedef struct {
    logic [2:0]  key;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulse_count = 0;
  int   cyc = 0;
  int   last_pulse = -1;

  camera_move_ctrl #(.UPDATE_PERIOD(UP), .SETTLE_CYC(SC)) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .frame_done(frame_done),
    .v0(v0),
    .v1(v1),
    .v2(v2),
    .ld_curr_camera(ld_curr_camera),
    .key(key),
    .cnt(cnt),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every update pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ld_curr_camera === 1'b1) begin
      exp_t e;
      pulse_count++;
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_key", 32'(key), 32'(e.key));
        check_output("pulse_cnt", cnt, e.cnt);
        check_output("pulse_on_v0", 32'(v0), 32'd1);
      end
      if (last_pulse >= 0)
        check_output("pulse_spacing", 32'((cyc - last_pulse) >= SC + 2), 32'd1);
      last_pulse = cyc;
    end
  end

  task automatic push_exp(input logic [2:0] k, input logic [31:0] c);
    exp_t e;
    e.key = k;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Drive a button pattern for a given number of sampling edges, then release
  task automatic apply_stimulus(input logic [5:0] pattern, input int edges);
    btn = pattern;
    repeat (edges) @(posedge clk);
    #1 btn = '0;
  endtask

  task automatic wait_pulses(input string name, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pulse_count >= target) break;
      @(posedge clk);
      #1;
    end
    check_output(name, 32'(pulse_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    check_output(name, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_v0"}, 32'(v0), 32'd1);
    check_output({tag, "_v1"}, 32'(v1), 32'd0);
    check_output({tag, "_v2"}, 32'(v2), 32'd0);
    check_output({tag, "_ld"}, 32'(ld_curr_camera), 32'd0);
    check_output({tag, "_key"}, 32'(key), 32'd0);
    check_output({tag, "_cnt"}, cnt, 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_ring(input string tag);
    @(negedge clk);
    check_output({tag, "_ring0"}, {29'd0, v2, v1, v0}, 32'b001);
    @(negedge clk);
    check_output({tag, "_ring1"}, {29'd0, v2, v1, v0}, 32'b010);
    @(negedge clk);
    check_output({tag, "_ring2"}, {29'd0, v2, v1, v0}, 32'b100);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    btn = '0;
    frame_done = 1'b1;
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk);
    #1 rst = 1'b0;
    check_ring("por");

    // Single press: V- sampled high for 10 edges
    @(posedge clk); #1;
    $display("[TB] single press");
    push_exp(3'b011, 32'd10);
    apply_stimulus(6'b001000, 10);
    wait_pulses("single_timeout", pulse_count + 1, 30);
    wait_idle("single_idle", 30);

    // Priority: W- and U- together, W- dropped early, U- held 8 edges
    $display("[TB] priority");
    push_exp(3'b001, 32'd8);
    btn = 6'b100010;
    repeat (3) @(posedge clk);
    #1 btn = 6'b000010;
    repeat (5) @(posedge clk);
    #1 btn = '0;
    wait_pulses("prio_timeout", pulse_count + 1, 30);
    wait_idle("prio_idle", 30);

    // Reset mid-HOLD with V+ held, then recovery press of 6 edges after release
    $display("[TB] reset mid-hold");
    btn = 6'b000100;
    repeat (6) @(posedge clk);
    #1;
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    push_exp(3'b010, 32'd6);
    check_ring("midrst");
    repeat (4) @(posedge clk);
    #1 btn = '0;
    wait_pulses("rst_recover_timeout", pulse_count + 1, 30);
    wait_idle("rst_recover_idle", 30);

    // Frame gating: no pulse while frame_done is low
    $display("[TB] frame gating");
    frame_done = 1'b0;
    push_exp(3'b100, 32'd5);
    apply_stimulus(6'b010000, 5);
    base = pulse_count;
    repeat (50) @(posedge clk);
    #1;
    check_output("gated_no_pulse", 32'(pulse_count), 32'(base));
    check_output("gated_busy", 32'(busy), 32'd1);
    frame_done = 1'b1;
    wait_pulses("gated_release_timeout", base + 1, 4);
    wait_idle("gated_idle", 30);

    // Release on the same cycle the hold count reaches the period
    $display("[TB] release coincident with period");
    base = pulse_count;
    push_exp(3'b000, 32'(UP));
    apply_stimulus(6'b000001, UP);
    wait_pulses("coinc_timeout", base + 1, 30);
    wait_idle("coinc_idle", 30);
    repeat (30) @(posedge clk);
    #1;
    check_output("coinc_single_pulse", 32'(pulse_count), 32'(base + 1));

`ifdef CAM_AUTOREPEAT_EN
    // Autorepeat: held U+ gives pulses of cnt = period; release right after the 4th
    $display("[TB] autorepeat");
    base = pulse_count;
    for (int i = 0; i < 4; i++) push_exp(3'b000, 32'(UP));
    btn = 6'b000001;
    wait_pulses("auto_timeout", base + 4, 200);
    btn = '0;
    wait_idle("auto_idle", 30);
    repeat (30) @(posedge clk);
    #1;
    check_output("auto_pulse_total", 32'(pulse_count), 32'(base + 4));
`else
    // Without autorepeat a long hold yields a single pulse carrying the full hold
    $display("[TB] long hold");
    base = pulse_count;
    push_exp(3'b000, 32'd100);
    apply_stimulus(6'b000001, 100);
    wait_pulses("long_timeout", base + 1, 30);
    wait_idle("long_idle", 30);
    repeat (30) @(posedge clk);
    #1;
    check_output("long_single_pulse", 32'(pulse_count), 32'(base + 1));
`endif

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
